// File: rtl/mux2_sel_arbiter.sv
// Round-robin owner of the mux2 select line, with a settle window after every sel change.
// Optional MUX2_ARB_LOCK_EN adds a lock input that suppresses MAX_HOLD preemption.
module mux2_sel_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned MAX_HOLD      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
`ifdef MUX2_ARB_LOCK_EN
  input  logic lock,
`endif
  output logic gnt0,
  output logic gnt1,
  output logic sel,
  output logic out_valid
);

  typedef enum logic [1:0] {IDLE, SETTLE, GRANT0, GRANT1} state_e;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);

  state_e     state_q, state_d;
  logic       sel_q, sel_d;
  logic       last_q, last_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] settle_q, settle_d;
  logic       gnt0_q, gnt1_q, ov_q;
  logic       lock_act;
  logic       tgt, req_sel, req_oth;

`ifdef MUX2_ARB_LOCK_EN
  assign lock_act = lock;
`else
  assign lock_act = 1'b0;
`endif

  // On a tie the requester that did not own the mux last wins.
  assign tgt     = (req0 && req1) ? ~last_q : req1;
  assign req_sel = sel_q ? req1 : req0;
  assign req_oth = sel_q ? req0 : req1;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    last_d   = last_q;
    hold_d   = hold_q;
    settle_d = settle_q;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          if (tgt == sel_q) begin
            state_d = tgt ? GRANT1 : GRANT0;
            last_d  = tgt;
            hold_d  = 8'd1;
          end else begin
            sel_d    = tgt;
            settle_d = SETTLE_LD;
            state_d  = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (settle_q != 4'd0) begin
          settle_d = settle_q - 4'd1;
        end else if (req_sel) begin
          state_d = sel_q ? GRANT1 : GRANT0;
          last_d  = sel_q;
          hold_d  = 8'd1;
        end else if (req_oth) begin
          sel_d    = ~sel_q;
          settle_d = SETTLE_LD;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT0, GRANT1: begin
        if (hold_q != HOLD_MAX) hold_d = hold_q + 8'd1;
        // In GRANT, sel always points at the grantee, so req_sel is its request.
        if (!req_sel) begin
          if (req_oth) begin
            sel_d    = ~sel_q;
            settle_d = SETTLE_LD;
            state_d  = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end else if (req_oth && (hold_q == HOLD_MAX) && !lock_act) begin
          sel_d    = ~sel_q;
          settle_d = SETTLE_LD;
          state_d  = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      last_q   <= 1'b1;
      hold_q   <= 8'd0;
      settle_q <= 4'd0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      hold_q   <= hold_d;
      settle_q <= settle_d;
      gnt0_q   <= (state_d == GRANT0);
      gnt1_q   <= (state_d == GRANT1);
      ov_q     <= (state_d == GRANT0) || (state_d == GRANT1);
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign sel       = sel_q;
  assign out_valid = ov_q;

endmodule

// File: tb/tb_mux2_sel_arbiter.sv
// Directed bench for mux2_sel_arbiter; expected {gnt0,gnt1,sel,out_valid} are queued per step.
module tb_mux2_sel_arbiter;

  logic clk = 1'b0;
  logic rst_n, req0, req1, lock;
  logic gnt0, gnt1, sel, out_valid;

  always #5 clk = ~clk;

  mux2_sel_arbiter #(.SETTLE_CYCLES(2), .MAX_HOLD(8)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
`ifdef MUX2_ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .out_valid(out_valid)
  );

  // {gnt0, gnt1, sel, out_valid}
  localparam logic [3:0] IDL0 = 4'b0000;  // idle or settling toward d0
  localparam logic [3:0] IDL1 = 4'b0010;  // idle or settling toward d1
  localparam logic [3:0] G0   = 4'b1001;
  localparam logic [3:0] G1   = 4'b0111;

  logic [3:0] exp_q[$];
  string      tag_q[$];
  int nchk = 0;
  int nfail = 0;

  task automatic check(input logic [3:0] obs, input logic [3:0] exp, input string tag);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs after the next edge, compare them.
  task automatic step(input logic rn, input logic r0, input logic r1,
                      input logic [3:0] exp, input string tag);
    logic [3:0] e;
    string      t;
    rst_n = rn; req0 = r0; req1 = r1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check({gnt0, gnt1, sel, out_valid}, e, t);
    check({3'b000, out_valid}, {3'b000, gnt0 | gnt1}, {t, "_ov_eq"});
    check({3'b000, gnt0 & gnt1}, 4'b0000, {t, "_mutex"});
    check({3'b000, (gnt0 && sel) || (gnt1 && !sel)}, 4'b0000, {t, "_sel_own"});
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; lock = 1'b0;
    @(negedge clk);
    step(0, 0, 0, IDL0, "reset_a");
    step(0, 0, 0, IDL0, "reset_b");
    step(1, 0, 0, IDL0, "idle");

    // req0 alone: 1-cycle latency, no settle, holds past MAX_HOLD with no competitor
    for (int i = 0; i < 11; i++) step(1, 1, 0, G0, "g0_solo");
    step(1, 0, 0, IDL0, "rel0");

    // req1 from sel=0: two dead cycles then grant
    step(1, 0, 1, IDL1, "s1_a");
    step(1, 0, 1, IDL1, "s1_b");
    for (int i = 0; i < 3; i++) step(1, 0, 1, G1, "g1");

    // handover: req1 drops while req0 rises on the same edge
    step(1, 1, 0, IDL0, "ho_s0_a");
    step(1, 1, 0, IDL0, "ho_s0_b");
    step(1, 1, 0, G0, "ho_g0");
    step(1, 0, 0, IDL0, "ho_rel");

    // both rise after reset: 8 gnt0, 2 dead, 8 gnt1, 2 dead, gnt0
    step(0, 0, 0, IDL0, "rst2");
    for (int i = 0; i < 8; i++) step(1, 1, 1, G0, "rr_g0");
    for (int i = 0; i < 2; i++) step(1, 1, 1, IDL1, "rr_s1");
    for (int i = 0; i < 8; i++) step(1, 1, 1, G1, "rr_g1");
    for (int i = 0; i < 2; i++) step(1, 1, 1, IDL0, "rr_s0");
    step(1, 1, 1, G0, "rr_g0_again");

    // reset mid-settle, then req1 settles again
    step(1, 0, 1, IDL1, "pre_rst_settle");
    step(0, 0, 1, IDL0, "rst_mid_settle");
    step(1, 0, 1, IDL1, "resettle_a");
    step(1, 0, 1, IDL1, "resettle_b");
    step(1, 0, 1, G1, "resettle_g1");

    // settle abandoned with no requester: back to idle, sel kept
    step(1, 0, 0, IDL1, "rel1_idle");
    step(1, 1, 0, IDL0, "ab_s0_a");
    step(1, 0, 0, IDL0, "ab_s0_b");
    step(1, 0, 0, IDL0, "ab_idle");
    step(1, 1, 0, G0, "ab_direct_g0");
    step(1, 0, 0, IDL0, "ab_rel");

    // settle redirected: req0 rising mid-settle is ignored until the count ends
    step(1, 0, 1, IDL1, "rd_s1_a");
    step(1, 1, 0, IDL1, "rd_s1_b");
    step(1, 1, 0, IDL0, "rd_flip");
    step(1, 1, 0, IDL0, "rd_s0");
    step(1, 1, 0, G0, "rd_g0");

`ifdef MUX2_ARB_LOCK_EN
    step(0, 0, 0, IDL0, "lk_rst");
    lock = 1'b1;
    for (int i = 0; i < 20; i++) step(1, 1, 1, G0, "lk_hold");
    lock = 1'b0;
    step(1, 1, 1, IDL1, "lk_preempt");
`endif

    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mux2_sel_arbiter.md
Name: mux2_sel_arbiter

Overview:
- Sequencing controller for the gate-level mux2 (2->1 multiplexer): it owns the mux select line and shares the mux between two requesters.
- Round-robin arbitration with a bounded hold time.
- Inserts a programmable settle window after every select change so the mux output (NOT/OR2 propagation, up to 10 time units) is stable before a grant is issued.
- Sits between the two source blocks and the mux2 instance; out_valid qualifies mux output z for downstream sampling.

Parameters:
- SETTLE_CYCLES, 2, dead cycles after a sel change before grant; legal 1..15.
- MAX_HOLD, 8, grant cycles after which a pending other requester preempts; legal 1..255.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst_n, input, 1, synchronous active-low reset, sampled on rising edge of clk.
- req0, input, 1, requester 0 wants the mux (drives mux d0).
- req1, input, 1, requester 1 wants the mux (drives mux d1).
- gnt0, output, 1, requester 0 owns the mux; z reflects d0.
- gnt1, output, 1, requester 1 owns the mux; z reflects d1.
- sel, output, 1, registered select to mux2 (0 = d0, 1 = d1).
- out_valid, output, 1, mux output z stable and owned (= gnt0 | gnt1).
- lock, input, 1, only present with MUX2_ARB_LOCK_EN (see Optional Feature).

Behaviour:
- Reset (rst_n low at a rising edge):
  - state=IDLE, sel=0, gnt0=gnt1=0, out_valid=0.
  - last=1, so req0 wins the first tie.
  - hold_cnt=0, settle_cnt=0.
  - Reset mid-SETTLE or mid-GRANT aborts immediately; outputs reach reset values after that edge.
- All outputs are registered; no combinational path from req to gnt.
- Target selection: only one req high -> that one. Both high -> the requester != last.
- IDLE:
  - No req: stay; sel holds its previous value.
  - Target == sel: go to GRANTx at the same edge; gnt visible after the edge that sampled req (1-cycle latency).
  - Target != sel: sel<=target, settle_cnt<=SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - gnt0=gnt1=0, out_valid=0.
  - Each edge: if settle_cnt!=0, decrement; else re-evaluate the target req.
  - Target req still high: go to GRANT(sel).
  - Target req low but other req high: start a new settle toward the other (sel flips, counter reloads).
  - Both req low: go to IDLE with sel kept.
  - With req sampled at edge N and sel != target, gnt is high after edge N+SETTLE_CYCLES.
- GRANTx:
  - gntx=1, out_valid=1.
  - On entry: last<=x, hold_cnt<=1. Each edge in GRANT: hold_cnt increments, saturating at MAX_HOLD.
  - reqx low, other req high: flip sel, go to SETTLE.
  - reqx low, other req low: go to IDLE with sel kept.
  - reqx high, other req high, hold_cnt==MAX_HOLD: preempt; gntx drops, sel flips, go to SETTLE.
  - reqx high, other req low: stay regardless of hold_cnt.
- Invariants the verifier asserts:
  - gnt0 & gnt1 never both high.
  - gnt never high in SETTLE.
  - sel never changes on an edge where any gnt was high before and after.
  - gntx high implies sel==x.
  - out_valid == gnt0|gnt1.
- Simultaneous events:
  - A grantee dropping req on the same edge MAX_HOLD is hit: treated as a normal release.
  - A req rising during SETTLE for the non-target side is ignored until the settle completes.

Optional Feature:
- Macro: MUX2_ARB_LOCK_EN.
- Defined:
  - The lock input port exists.
  - While the current grantee holds lock=1, MAX_HOLD preemption is suppressed (hold_cnt still saturates).
  - Release on reqx low is unaffected.
  - lock is ignored outside GRANT.
- Undefined:
  - No lock port.
  - Preemption at MAX_HOLD is unconditional.

Test Plan:
- Reset then req0=1 held: gnt0=1 one cycle after the sampling edge, sel=0 throughout, no SETTLE entered.
- From IDLE with sel=0, req1=1 (SETTLE_CYCLES=2): sel=1 after edge N, gnt1=1 after edge N+2, out_valid low for exactly 2 cycles.
- req0 and req1 both rise in the same cycle after reset: gnt0 first; MAX_HOLD=8 gives 8 gnt0 cycles, 2 dead cycles, then gnt1. Alternation continues while both are held.
- req1 granted, then req1 drops and req0 rises on the same edge: sel flips to 0, gnt0 after 2 settle cycles; gnt1 and gnt0 never overlap.
- rst_n low for one edge during SETTLE: next cycle state IDLE, sel=0, gnts=0, out_valid=0. A subsequent req1 re-enters SETTLE.
- With MUX2_ARB_LOCK_EN: gnt0 held with lock=1 and req1 pending for 20 cycles keeps gnt0 high for all 20. Deasserting lock preempts on the next edge (hold_cnt is saturated).
